// File: rtl/shift_pkg.sv
// Shared types and constants for the execute-stage shift/rotate unit.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
// Optional feature macro: SHIFT_STAGE_FLAGS_EN adds carry/zero to each buffered entry.
package shift_pkg;

  localparam int SHIFT_W = 16;
  localparam int CNT_W   = 4;

  // Opcode encodings as presented by the ID/EX register.
  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } shiftOp_t;

  // Occupancy of the 2-entry output skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } bufState_t;

  // One buffered result; flags only exist when the flag feature is built in.
  typedef struct packed {
`ifdef SHIFT_STAGE_FLAGS_EN
    logic               carry;
    logic               zero;
`endif
    logic [SHIFT_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/shift_rotate_core.sv
// Combinational 4-level log shifter (1/2/4/8) for ROL/SLL/ROR/SRL.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides when the result is captured.
// Ports: data/cnt/op in, result out; carry/zero out only with SHIFT_STAGE_FLAGS_EN.
module shift_rotate_core
  import shift_pkg::*;
(
  input  logic [SHIFT_W-1:0] data,
  input  logic [CNT_W-1:0]   cnt,
  input  shiftOp_t           op,
  output logic [SHIFT_W-1:0] result
`ifdef SHIFT_STAGE_FLAGS_EN
  ,
  output logic               carry,
  output logic               zero
`endif
);

  // lvl[k] is the operand after the first k count bits have been applied.
  logic [CNT_W:0][SHIFT_W-1:0] lvl;
`ifdef SHIFT_STAGE_FLAGS_EN
  // lvlCarry[k] is the last bit moved out so far; 0 until any stage fires.
  logic [CNT_W:0] lvlCarry;
  assign lvlCarry[0] = 1'b0;
`endif

  assign lvl[0] = data;

  for (genvar k = 0; k < CNT_W; k++) begin : gLevel
    localparam int AMT = 1 << k;
    logic [SHIFT_W-1:0] moved;

    always_comb begin
      case (op)
        OP_ROL:  moved = {lvl[k][SHIFT_W-AMT-1:0], lvl[k][SHIFT_W-1:SHIFT_W-AMT]};
        OP_SLL:  moved = {lvl[k][SHIFT_W-AMT-1:0], {AMT{1'b0}}};
        OP_ROR:  moved = {lvl[k][AMT-1:0], lvl[k][SHIFT_W-1:AMT]};
        default: moved = {{AMT{1'b0}}, lvl[k][SHIFT_W-1:AMT]};
      endcase
    end

    assign lvl[k+1] = cnt[k] ? moved : lvl[k];

`ifdef SHIFT_STAGE_FLAGS_EN
    // The lowest bit leaving the top (left ops) or the highest bit leaving the
    // bottom (right ops) of the last active stage is the overall last bit out.
    // For rotates that bit lands in result[0] / result[15] respectively.
    logic outBit;
    assign outBit = (op == OP_ROL || op == OP_SLL) ? lvl[k][SHIFT_W-AMT]
                                                   : lvl[k][AMT-1];
    assign lvlCarry[k+1] = cnt[k] ? outBit : lvlCarry[k];
`endif
  end

  assign result = lvl[CNT_W];

`ifdef SHIFT_STAGE_FLAGS_EN
  assign carry = lvlCarry[CNT_W];
  assign zero  = (lvl[CNT_W] == '0);
`endif

endmodule

// File: rtl/shift_stage.sv
// Execute-stage shift/rotate unit feeding EX/MEM through a 2-entry skid buffer.
// Latency: 1 cycle from accept to out_valid when empty; 1 result/cycle sustained.
// Backpressure: in_ready depends only on registered occupancy (not FULL); no comb path from out_ready.
// Ports: clk, rst_n, in_valid/in_ready/in_op/in_data/in_cnt, flush,
//        out_valid/out_ready/out_data, out_carry/out_zero with SHIFT_STAGE_FLAGS_EN.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_W  // must equal SHIFT_W; count is fixed at CNT_W bits
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       in_cnt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SHIFT_STAGE_FLAGS_EN
  ,
  output logic             out_carry,
  output logic             out_zero
`endif
);

  bufState_t          state;
  entry_t             headEntry;
  entry_t             tailEntry;
  entry_t             newEntry;
  logic [SHIFT_W-1:0] coreResult;
  logic               accept;
  logic               pop;
`ifdef SHIFT_STAGE_FLAGS_EN
  logic               coreCarry;
  logic               coreZero;
`endif

  shift_rotate_core uCore (
    .data   (in_data),
    .cnt    (in_cnt),
    .op     (shiftOp_t'(in_op)),
    .result (coreResult)
`ifdef SHIFT_STAGE_FLAGS_EN
    ,
    .carry  (coreCarry),
    .zero   (coreZero)
`endif
  );

  always_comb begin
    newEntry      = '0;
    newEntry.data = coreResult;
`ifdef SHIFT_STAGE_FLAGS_EN
    newEntry.carry = coreCarry;
    newEntry.zero  = coreZero;
`endif
  end

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head is cleared whenever it stops holding a live entry, so the outputs
  // read as zero while out_valid is low without any output muxing.
  assign out_data = headEntry.data;
`ifdef SHIFT_STAGE_FLAGS_EN
  assign out_carry = headEntry.carry;
  assign out_zero  = headEntry.zero;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      headEntry <= '0;
      tailEntry <= '0;
    end else if (flush) begin
      // Flush wins: any same-cycle input is dropped; a same-cycle pop was
      // already taken downstream, so clearing everything is consistent.
      state     <= ST_EMPTY;
      headEntry <= '0;
      tailEntry <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state     <= ST_ONE;
            headEntry <= newEntry;
          end
        end
        ST_ONE: begin
          if (accept && !pop) begin
            state     <= ST_FULL;
            tailEntry <= newEntry;
          end else if (accept && pop) begin
            headEntry <= newEntry;
          end else if (pop) begin
            state     <= ST_EMPTY;
            headEntry <= '0;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state     <= ST_ONE;
            headEntry <= tailEntry;
            tailEntry <= '0;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          headEntry <= '0;
          tailEntry <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_stage.sv
// Self-checking bench for shift_stage: directed table, multi-cycle sequences,
// and randomized traffic against a queue-based reference model.
module tb_shift_stage;

  localparam logic [1:0] ROL = 2'b00;
  localparam logic [1:0] SLL = 2'b01;
  localparam logic [1:0] ROR = 2'b10;
  localparam logic [1:0] SRL = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [15:0] in_data = 16'h0000;
  logic [3:0]  in_cnt = 4'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
`ifdef SHIFT_STAGE_FLAGS_EN
  logic        out_carry;
  logic        out_zero;
`endif

  int total = 0;
  int bad   = 0;
  bit monEn = 1'b0;

  typedef struct {
    logic [15:0] d;
    logic        c;
    logic        z;
  } res_t;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] x;
    logic [3:0]  n;
    logic [15:0] d;
    logic        c;
    logic        z;
  } vec_t;

  res_t        expQ[$];
  vec_t        vecs[13];
  logic [1:0]  bOp[20];
  logic [15:0] bX[20];
  logic [3:0]  bN[20];

  always #5 clk = ~clk;

  shift_stage #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SHIFT_STAGE_FLAGS_EN
    ,
    .out_carry (out_carry),
    .out_zero  (out_zero)
`endif
  );

  // Reference: shift/rotate from the arithmetic definitions on a 32-bit word.
  function automatic res_t refShift(input logic [1:0] op, input logic [15:0] x,
                                    input logic [3:0] cnt);
    int          n;
    logic [31:0] w;
    logic [31:0] r;
    res_t        o;
    n = int'(cnt);
    w = {16'h0000, x};
    case (op)
      ROL:     r = (w << n) | (w >> (16 - n));
      SLL:     r = w << n;
      ROR:     r = (w >> n) | (w << (16 - n));
      default: r = w >> n;
    endcase
    o.d = r[15:0];
    if (n == 0) o.c = 1'b0;
    else begin
      case (op)
        SLL:     o.c = x[16 - n];
        SRL:     o.c = x[n - 1];
        ROL:     o.c = o.d[0];
        default: o.c = o.d[15];
      endcase
    end
    o.z = (o.d == 16'h0000);
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] op, input logic [15:0] x, input logic [3:0] n);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = x;
    in_cnt   = n;
  endtask

  // Cycle monitor: DUT outputs versus a FIFO of expected results. Inputs only
  // change just after posedge, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (monEn) begin
      bit canAccept;
      chk("mon_out_valid", out_valid, expQ.size() != 0);
      chk("mon_in_ready", in_ready, expQ.size() < 2);
      if (expQ.size() != 0) begin
        chk("mon_out_data", out_data, expQ[0].d);
`ifdef SHIFT_STAGE_FLAGS_EN
        chk("mon_carry", out_carry, expQ[0].c);
        chk("mon_zero", out_zero, expQ[0].z);
`endif
      end else begin
        chk("mon_idle_data", out_data, 0);
      end
      canAccept = (expQ.size() < 2);
      if (expQ.size() != 0 && out_ready) expQ.delete(0);
      if (flush) expQ.delete();
      else if (in_valid && canAccept) expQ.push_back(refShift(in_op, in_data, in_cnt));
    end
  end

  initial begin
    res_t        r;
    logic [15:0] got[$];
    bit          acc;
    bit          rdySeen;

    // Reset state, before any clock edge.
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef SHIFT_STAGE_FLAGS_EN
    chk("rst_carry", out_carry, 0);
    chk("rst_zero", out_zero, 0);
`endif
    #5 rst_n = 1'b1;
    tick();
    monEn = 1'b1;

    // Directed table: op, operand, count, expected data/carry/zero.
    vecs[0]  = '{SLL, 16'h0001, 4'd15, 16'h8000, 1'b0, 1'b0};
    vecs[1]  = '{SRL, 16'h8000, 4'd15, 16'h0001, 1'b0, 1'b0};
    vecs[2]  = '{ROL, 16'h8001, 4'd1,  16'h0003, 1'b1, 1'b0};
    vecs[3]  = '{ROR, 16'h8001, 4'd1,  16'hC000, 1'b1, 1'b0};
    vecs[4]  = '{ROL, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0, 1'b0};
    vecs[5]  = '{SLL, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0, 1'b0};
    vecs[6]  = '{ROR, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0, 1'b0};
    vecs[7]  = '{SRL, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0, 1'b0};
    vecs[8]  = '{SLL, 16'h8000, 4'd1,  16'h0000, 1'b1, 1'b1};
    vecs[9]  = '{SRL, 16'h0003, 4'd1,  16'h0001, 1'b1, 1'b0};
    vecs[10] = '{ROL, 16'h1234, 4'd4,  16'h2341, 1'b1, 1'b0};
    vecs[11] = '{ROR, 16'h1234, 4'd4,  16'h4123, 1'b0, 1'b0};
    vecs[12] = '{SLL, 16'h00F0, 4'd12, 16'h0000, 1'b1, 1'b1};

    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      offer(vecs[i].op, vecs[i].x, vecs[i].n);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].d);
`ifdef SHIFT_STAGE_FLAGS_EN
      chk($sformatf("vec%0d_carry", i), out_carry, vecs[i].c);
      chk($sformatf("vec%0d_zero", i), out_zero, vecs[i].z);
`endif
      tick();
    end
    @(negedge clk);
    chk("idle_valid", out_valid, 0);
    chk("idle_data", out_data, 0);
    tick();

    // Backpressure: two accepts fill the buffer, the third is held.
    out_ready = 1'b0;
    offer(SLL, 16'h0001, 4'd1);
    tick();
    in_cnt = 4'd2;
    tick();
    in_cnt = 4'd3;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_head_hold", out_data, 16'h0002);
      tick();
    end
    out_ready = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) got.push_back(out_data);
      if (in_valid && in_ready) acc = 1'b1;
      tick();
      if (acc) in_valid = 1'b0;
    end
    chk("bp_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("bp_first", got[0], 16'h0002);
      chk("bp_second", got[1], 16'h0004);
      chk("bp_third", got[2], 16'h0008);
    end

    // Back-to-back accept+pop: each result appears the cycle after its accept.
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) begin
        bOp[i] = 2'($urandom_range(0, 3));
        bX[i]  = 16'($urandom_range(0, 65535));
        bN[i]  = 4'($urandom_range(0, 15));
        offer(bOp[i], bX[i], bN[i]);
      end else begin
        in_valid = 1'b0;
      end
      if (i > 0) begin
        @(negedge clk);
        r = refShift(bOp[i-1], bX[i-1], bN[i-1]);
        chk($sformatf("b2b%0d_valid", i - 1), out_valid, 1);
        chk($sformatf("b2b%0d_ready", i - 1), in_ready, 1);
        chk($sformatf("b2b%0d_data", i - 1), out_data, r.d);
      end
      tick();
    end

    // Flush while FULL with a valid input present.
    out_ready = 1'b0;
    offer(SLL, 16'h0001, 4'd4);
    tick();
    in_data = 16'h0002;
    tick();
    offer(ROL, 16'hBEEF, 4'd3);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_out_data", out_data, 0);
    tick();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("flush_input_dropped", out_valid, 0);
      tick();
    end

    // Asynchronous reset while FULL.
    out_ready = 1'b0;
    offer(SRL, 16'hF000, 4'd4);
    tick();
    in_data = 16'h0F00;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_full", in_ready, 0);
    chk("pre_rst_valid", out_valid, 1);
    tick();
    monEn = 1'b0;
    expQ.delete();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_ready", in_ready, 1);
    tick();
    tick();
    rst_n     = 1'b1;
    monEn     = 1'b1;
    out_ready = 1'b1;
    offer(SLL, 16'h0003, 4'd2);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_first_valid", out_valid, 1);
    chk("post_rst_first_data", out_data, 16'h000C);
    tick();

    // Randomized traffic with stalls and occasional flushes; monitor checks.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rdySeen = in_ready;
      tick();
      if (!(in_valid && !rdySeen && !flush)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op    = 2'($urandom_range(0, 3));
        in_data  = 16'($urandom_range(0, 65535));
        in_cnt   = 4'($urandom_range(0, 15));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
    end

    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    @(negedge clk);
    chk("drain_empty", out_valid, 0);
    chk("drain_model_empty", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
